// File: rtl/iomem_router_pkg.sv
// iomem_router_pkg: FSM states, slot map, status offsets and address routing shared by the router
package iomem_router_pkg;

    typedef enum logic [2:0] {IDLE, ACCESS, INTERNAL, ERROR, DONE} state_t;

    localparam logic [2:0] SLOT_GPIO   = 3'd3;
    localparam logic [2:0] SLOT_AUDIO  = 3'd4;
    localparam logic [2:0] SLOT_VIDEO  = 3'd5;
    localparam logic [2:0] SLOT_STATUS = 3'd6;
    localparam logic [2:0] SLOT_I2C    = 3'd7;

    localparam logic [23:0] OFS_ERR_COUNT = 24'h00_0000;
    localparam logic [23:0] OFS_LAST_ERR  = 24'h00_0004;

    function automatic state_t route(input logic [31:0] addr);
        return (addr[31:27] != 5'd0) ? ERROR :
               (addr[26:24] == SLOT_STATUS) ? INTERNAL :
               (addr[26:24] inside {SLOT_GPIO, SLOT_AUDIO, SLOT_VIDEO, SLOT_I2C}) ? ACCESS : ERROR;
    endfunction

endpackage

// File: rtl/iomem_router_status.sv
// iomem_router_status: saturating error counter, last error address and error interrupt
module iomem_router_status (
    input  logic        clk,
    input  logic        resetn,
    input  logic        log_err,
    input  logic        clr,
    input  logic [31:0] err_addr,
    output logic [15:0] err_count,
    output logic [31:0] last_err_addr,
    output logic        err_irq
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_count     <= '0;
            last_err_addr <= '0;
        end else if (clr) begin
            err_count <= '0;
        end else if (log_err) begin
            err_count     <= err_count + 16'(err_count != 16'hFFFF);
            last_err_addr <= err_addr;
        end
    end

    assign err_irq = err_count != 16'h0;

endmodule

// File: rtl/iomem_router.sv
// iomem_router: routes CPU iomem transactions to one-hot slave slots with timeout and error status
module iomem_router
    import iomem_router_pkg::*;
#(
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         m_valid,
    output logic         m_ready,
    input  logic [3:0]   m_wstrb,
    input  logic [31:0]  m_addr,
    input  logic [31:0]  m_wdata,
    output logic [31:0]  m_rdata,
    output logic [7:0]   s_valid,
    input  logic [7:0]   s_ready,
    input  logic [255:0] s_rdata,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
    output logic         err_irq
);

    state_t      state, state_nxt;
    logic [2:0]  slot_q;
    logic [15:0] cnt_q;
    logic        hit, expire, resp, log_err, clr;
    logic [23:0] ofs;
    logic [31:0] slot_rdata, stat_rdata, rdata_nxt, last_err_addr;
    logic [15:0] err_count;

    assign s_addr     = m_addr;
    assign s_wdata    = m_wdata;
    assign s_wstrb    = m_wstrb;
    assign ofs        = m_addr[23:0];
    assign s_valid    = (state == ACCESS) ? 8'b1 << slot_q : 8'h0;
    assign hit        = s_ready[slot_q];
    assign expire     = cnt_q == 16'(TIMEOUT - 1);
    assign slot_rdata = s_rdata[{slot_q, 5'd0} +: 32];
    assign stat_rdata = (ofs == OFS_ERR_COUNT) ? {16'h0, err_count} :
                        (ofs == OFS_LAST_ERR)  ? last_err_addr : 32'h0;

    // a completing slave wins over a timeout expiring in the same cycle
    always_comb begin
        state_nxt = state;
        resp      = 1'b0;
        log_err   = 1'b0;
        clr       = 1'b0;
        rdata_nxt = ERR_RDATA;
        case (state)
            IDLE:     state_nxt = m_valid ? route(m_addr) : IDLE;
            ACCESS: begin
                resp      = hit || expire;
                log_err   = !hit && expire;
                rdata_nxt = hit ? slot_rdata : ERR_RDATA;
                state_nxt = (hit || expire) ? DONE : ACCESS;
            end
            INTERNAL: begin
                resp      = 1'b1;
                rdata_nxt = stat_rdata;
                clr       = (ofs == OFS_ERR_COUNT) && (m_wstrb != 4'h0);
                state_nxt = DONE;
            end
            ERROR: begin
                resp      = 1'b1;
                log_err   = 1'b1;
                state_nxt = DONE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            slot_q  <= '0;
            cnt_q   <= '0;
            m_ready <= 1'b0;
            m_rdata <= '0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= (state == ACCESS) ? cnt_q + 16'd1 : 16'd0;
            m_ready <= resp;
            if (resp) m_rdata <= rdata_nxt;
            if (state == IDLE && m_valid) slot_q <= m_addr[26:24];
        end
    end

    iomem_router_status u_status (
        .clk           (clk),
        .resetn        (resetn),
        .log_err       (log_err),
        .clr           (clr),
        .err_addr      (m_addr),
        .err_count     (err_count),
        .last_err_addr (last_err_addr),
        .err_irq       (err_irq)
    );

endmodule

// File: tb/tb_iomem_router.sv
// tb_iomem_router: directed vector table, random transactions against a reference model, reset and saturation
module tb_iomem_router;

    localparam int          TO   = 16;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    logic         clk = 1'b0, resetn = 1'b0, m_valid = 1'b0;
    logic         m_ready, err_irq;
    logic [3:0]   m_wstrb = '0, s_wstrb;
    logic [31:0]  m_addr = '0, m_wdata = '0, m_rdata, s_addr, s_wdata;
    logic [7:0]   s_valid, s_ready = '0;
    logic [255:0] s_rdata = '0;

    logic         sat_rstn = 1'b0, sat_log = 1'b0, sat_clr = 1'b0, sat_irq;
    logic [31:0]  sat_addr = '0, sat_last;
    logic [15:0]  sat_count;
    bit           sat_done = 1'b0;

    int total = 0, bad = 0;
    logic [15:0] mcnt;
    logic [31:0] mlast;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        int          delay;
        logic [7:0]  stray;
        logic [31:0] sdata;
        bit          chk;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [7:0]  exp_sv;
        logic        exp_irq;
    } vec_t;

    vec_t vt [22];

    always #5 clk = ~clk;

    iomem_router #(.TIMEOUT(TO), .ERR_RDATA(BEEF)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_ready(m_ready), .m_wstrb(m_wstrb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_rdata(m_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_rdata(s_rdata),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .err_irq(err_irq)
    );

    iomem_router_status u_sat (
        .clk(clk), .resetn(sat_rstn), .log_err(sat_log), .clr(sat_clr), .err_addr(sat_addr),
        .err_count(sat_count), .last_err_addr(sat_last), .err_irq(sat_irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // one master transaction; the slave raises its ready bit on access cycle 'delay' (-1: never)
    task automatic xact(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                        input int delay, input logic [7:0] stray, input logic [31:0] sdata,
                        output logic [31:0] rd, output int lat, output int pulses, output logic [7:0] sv_seen);
        logic [2:0] slot;
        int acc;
        slot = addr[26:24];
        acc = -1; rd = '0; lat = 0; pulses = 0; sv_seen = '0;
        for (int n = 0; n < 8; n++) s_rdata[32*n +: 32] = (n == int'(slot)) ? sdata : (32'hBAD0_0000 | 32'(n));
        m_addr = addr; m_wstrb = wstrb; m_wdata = wdata; m_valid = 1'b1; s_ready = '0;
        #1;
        check("copy_addr", s_addr, addr);
        check("copy_wdata", s_wdata, wdata);
        check("copy_wstrb", 32'(s_wstrb), 32'(wstrb));
        for (int c = 1; c <= 100 && pulses == 0; c++) begin
            @(posedge clk); #1;
            if (s_valid != 8'h0) begin
                acc++;
                sv_seen |= s_valid;
            end
            s_ready = (s_valid != 8'h0) ? ((acc == delay) ? 8'b1 << slot : stray) : 8'h0;
            if (m_ready) begin
                pulses = 1; rd = m_rdata; lat = c;
            end
        end
        m_valid = 1'b0; s_ready = '0;
        @(posedge clk); #1;
        check("sv_after", 32'(s_valid), 32'h0);
        if (m_ready) pulses++;
    endtask

    task automatic judge(input string tag, input logic [31:0] rd, input int lat, input int pulses,
                         input logic [7:0] sv, input bit chk, input logic [31:0] exp_rd,
                         input int exp_lat, input logic [7:0] exp_sv, input logic exp_irq);
        if (chk) check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_svalid"}, 32'(sv), 32'(exp_sv));
        check({tag, "_irq"}, 32'(err_irq), 32'(exp_irq));
    endtask

    // reference model: expected response straight from the address map and status-register rules
    task automatic model(input logic [31:0] addr, input logic [3:0] wstrb, input int delay,
                         input logic [31:0] sdata, output logic [31:0] rd, output bit chk,
                         output int lat, output logic [7:0] sv);
        logic [2:0] slot;
        bit mapped, ext, stat;
        slot   = addr[26:24];
        mapped = addr[31:27] == 5'd0;
        ext    = mapped && (slot == 3'd3 || slot == 3'd4 || slot == 3'd5 || slot == 3'd7);
        stat   = mapped && slot == 3'd6;
        chk = 1'b1; lat = 2; sv = ext ? 8'b1 << slot : 8'h0;
        if (stat) begin
            rd  = (addr[23:0] == 24'h0) ? {16'h0, mcnt} : (addr[23:0] == 24'h4) ? mlast : 32'h0;
            chk = wstrb == 4'h0;
            if (wstrb != 4'h0 && addr[23:0] == 24'h0) mcnt = 16'h0;
        end else if (ext && delay >= 0 && delay < TO) begin
            rd = sdata; lat = 2 + delay;
        end else begin
            rd = BEEF; lat = ext ? TO + 1 : 2;
            mcnt = (mcnt == 16'hFFFF) ? mcnt : mcnt + 16'd1;
            mlast = addr;
        end
    endtask

    task automatic run_model(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                             input int delay, input logic [7:0] stray);
        logic [31:0] rd, erd, sdata, wdata;
        logic [7:0] sv, esv;
        int lat, elat, pulses;
        bit chk;
        sdata = $urandom; wdata = $urandom;
        model(addr, wstrb, delay, sdata, erd, chk, elat, esv);
        xact(addr, wstrb, wdata, delay, stray, sdata, rd, lat, pulses, sv);
        judge(tag, rd, lat, pulses, sv, chk, erd, elat, esv, mcnt != 16'h0);
    endtask

    initial begin
        logic [31:0] rd, addr;
        logic [7:0] sv, stray;
        logic [2:0] slot;
        int lat, pulses, rdy, svc, kind;
        logic [2:0] ext_slots [4] = '{3'd3, 3'd4, 3'd5, 3'd7};

        vt[0]  = '{32'h0300_0000, 4'h0,  3, 8'h00, 32'h0000_00A5, 1'b1, 32'h0000_00A5,  5, 8'h08, 1'b0};
        vt[1]  = '{32'h0500_0010, 4'hF, -1, 8'h00, 32'h1234_5678, 1'b1, BEEF,          17, 8'h20, 1'b1};
        vt[2]  = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0000_0001,  2, 8'h00, 1'b1};
        vt[3]  = '{32'h0600_0000, 4'hF, -1, 8'h00, 32'h0,         1'b0, 32'h0,          2, 8'h00, 1'b0};
        vt[4]  = '{32'h0600_0004, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0500_0010,  2, 8'h00, 1'b0};
        vt[5]  = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0,          2, 8'h00, 1'b0};
        vt[6]  = '{32'h0100_0000, 4'h0, -1, 8'h00, 32'h5555_AAAA, 1'b1, BEEF,           2, 8'h00, 1'b1};
        vt[7]  = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0000_0001,  2, 8'h00, 1'b1};
        vt[8]  = '{32'h0700_0000, 4'h0, 15, 8'h10, 32'h7777_0007, 1'b1, 32'h7777_0007, 17, 8'h80, 1'b1};
        vt[9]  = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0000_0001,  2, 8'h00, 1'b1};
        vt[10] = '{32'h0400_0000, 4'h3, 16, 8'h00, 32'h4444_4444, 1'b1, BEEF,          17, 8'h10, 1'b1};
        vt[11] = '{32'h0800_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, BEEF,           2, 8'h00, 1'b1};
        vt[12] = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0000_0003,  2, 8'h00, 1'b1};
        vt[13] = '{32'h0600_0004, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0800_0000,  2, 8'h00, 1'b1};
        vt[14] = '{32'h0600_0008, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0,          2, 8'h00, 1'b1};
        vt[15] = '{32'h0600_0004, 4'hF, -1, 8'h00, 32'h0,         1'b0, 32'h0,          2, 8'h00, 1'b1};
        vt[16] = '{32'h0600_0000, 4'h2, -1, 8'h00, 32'h0,         1'b0, 32'h0,          2, 8'h00, 1'b0};
        vt[17] = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0,          2, 8'h00, 1'b0};
        vt[18] = '{32'h0000_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, BEEF,           2, 8'h00, 1'b1};
        vt[19] = '{32'h0200_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, BEEF,           2, 8'h00, 1'b1};
        vt[20] = '{32'h0600_0000, 4'h0, -1, 8'h00, 32'h0,         1'b1, 32'h0000_0002,  2, 8'h00, 1'b1};
        vt[21] = '{32'h0300_0040, 4'h1,  0, 8'hF7, 32'h0303_0303, 1'b1, 32'h0303_0303,  2, 8'h08, 1'b1};

        #2;
        check("rst_m_ready", 32'(m_ready), 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_err_irq", 32'(err_irq), 32'h0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1; sat_rstn = 1'b1;

        for (int i = 0; i < 22; i++) begin
            xact(vt[i].addr, vt[i].wstrb, 32'hC0FF_EE00 + 32'(i), vt[i].delay, vt[i].stray, vt[i].sdata,
                 rd, lat, pulses, sv);
            judge($sformatf("vec%0d", i), rd, lat, pulses, sv, vt[i].chk, vt[i].exp_rd,
                  vt[i].exp_lat, vt[i].exp_sv, vt[i].exp_irq);
        end

        mcnt = 16'd2; mlast = 32'h0200_0000;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 3);
            stray = 8'h0;
            if (kind < 2) begin
                slot  = ext_slots[$urandom_range(0, 3)];
                addr  = {5'b0, slot, 24'($urandom) & 24'hFF_FFFC};
                stray = 8'($urandom) & ~(8'b1 << slot);
                run_model($sformatf("rnd%0d", i), addr, 4'($urandom), $urandom_range(0, 20), stray);
            end else if (kind == 2) begin
                addr = {5'b0, 3'd6, 24'(4 * $urandom_range(0, 3))};
                run_model($sformatf("rnd%0d", i), addr, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, -1, stray);
            end else begin
                addr = ($urandom_range(0, 1) == 0) ? {5'b0, 3'($urandom_range(0, 2)), 24'($urandom)}
                                                   : {5'($urandom_range(1, 31)), 27'($urandom)};
                run_model($sformatf("rnd%0d", i), addr, 4'($urandom), -1, stray);
            end
        end

        run_model("pre_rst_err", 32'h0100_0000, 4'h0, -1, 8'h0);
        m_addr = 32'h0300_0000; m_wstrb = 4'h0; m_valid = 1'b1; s_ready = '0;
        repeat (4) @(posedge clk);
        #1 check("rst_mid_sv_pre", 32'(s_valid), 32'h08);
        resetn = 1'b0;
        #1;
        check("rst_mid_s_valid", 32'(s_valid), 32'h0);
        check("rst_mid_m_ready", 32'(m_ready), 32'h0);
        check("rst_mid_m_rdata", m_rdata, 32'h0);
        check("rst_mid_err_irq", 32'(err_irq), 32'h0);
        m_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        rdy = 0; svc = 0;
        repeat (20) begin
            @(posedge clk); #1;
            rdy += int'(m_ready);
            if (s_valid != 8'h0) svc++;
        end
        check("rst_no_ready", rdy, 0);
        check("rst_no_svalid", svc, 0);
        mcnt = 16'h0; mlast = 32'h0;
        run_model("post_rst_cnt", 32'h0600_0000, 4'h0, -1, 8'h0);
        run_model("post_rst_last", 32'h0600_0004, 4'h0, -1, 8'h0);

        for (int c = 0; c < 70000 && !sat_done; c++) @(posedge clk);
        check("sat_finished", 32'(sat_done), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // 65536 back-to-back error logs straight into the status block
    initial begin
        @(posedge sat_rstn);
        @(posedge clk); #1;
        sat_log = 1'b1;
        for (int i = 1; i <= 65536; i++) begin
            @(posedge clk); #1;
            sat_addr = 32'(i);
            if (i == 65534) check("sat_near", 32'(sat_count), 32'h0000_FFFE);
        end
        check("sat_count", 32'(sat_count), 32'h0000_FFFF);
        check("sat_last", sat_last, 32'd65535);
        check("sat_irq", 32'(sat_irq), 32'h1);
        sat_log = 1'b0; sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        check("sat_clear", 32'(sat_count), 32'h0);
        check("sat_clear_irq", 32'(sat_irq), 32'h0);
        sat_done = 1'b1;
    end

endmodule
